led_flow_ctrl: RTL and testbench
================================

LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, sets clk cycles per LED step (0.5 s at 50 MHz); legal range >= 1.
REQ-002 Parameter WIDTH, default 8, sets LED vector width; fixed at 8 for this release.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request: begin or restart a run in the selected mode.
REQ-006 stop  input  1  one-cycle request: end the run and hold the LED pattern.
REQ-007 pause  input  1  level; while high, stepping is frozen.
REQ-008 mode  input  2  00 none, 01 rotate-left, 10 rotate-right, 11 bounce; sampled only when start is accepted.
REQ-009 led  output  8  one-hot LED pattern, registered.
REQ-010 busy  output  1  high in RUN and HOLD states, registered.
REQ-011 wrap  output  1  one-cycle pulse on end-of-sweep events (REQ-022), registered.

Function
REQ-012 FSM states: IDLE, RUN, HOLD. Direction register dir (L/R) and bounce flag bnc record the active mode.
REQ-013 Step counter cnt, width max(1, clog2(TICK_DIV)):
  - increments only in cycles where state == RUN and pause == 0;
  - tick = that condition with cnt == TICK_DIV-1; on tick, cnt <= 0;
  - TICK_DIV = 1 gives a tick every RUN cycle.
REQ-014 Start acceptance: start=1, stop=0 and mode != 00, in any state. At that edge:
  - led <= 0000_0001 for modes 01/11, or 1000_0000 for mode 10;
  - cnt <= 0, state <= RUN;
  - dir and bnc are set from mode.
REQ-015 start with mode 00 is ignored in every state.
REQ-016 start while in RUN or HOLD restarts the run per REQ-014, and any pause in progress is abandoned.
REQ-017 stop=1 in RUN or HOLD: state <= IDLE, led holds its value, cnt <= 0. stop in IDLE has no effect.
REQ-018 start and stop in the same cycle: stop wins.
REQ-019 Step timing: if start is accepted at edge N, the first led change occurs at edge N+TICK_DIV, and every TICK_DIV RUN cycles after that.
REQ-020 Step rules on a tick:
  - dir L: led <= {led[6:0], led[7]};
  - dir R: led <= {led[0], led[7:1]}.
REQ-021 Bounce (bnc=1), on a tick:
  - dir L and led == 1000_0000: led <= 0100_0000, dir <= R;
  - dir R and led == 0000_0001: led <= 0000_0010, dir <= L;
  - no rotation wrap ever occurs in bounce mode.
REQ-022 wrap is high for exactly the cycle after the edge on which any of these occurs:
  - left rotate 1000_0000 -> 0000_0001;
  - right rotate 0000_0001 -> 1000_0000;
  - bounce reversal at either end.
REQ-023 Pause behaviour:
  - RUN with pause=1: no count, no step; next state HOLD;
  - HOLD with pause=1: stay in HOLD;
  - HOLD with pause=0: go to RUN, no count that cycle;
  - cnt is preserved throughout, so a pause held P cycles delays the next step by P+1 cycles.
REQ-024 In IDLE, led holds, cnt holds at 0 and wrap is 0.
REQ-025 led is always one-hot.

Reset
REQ-026 On rst=1 at an edge, regardless of state or other inputs: led <= 0000_0001, state <= IDLE, cnt <= 0, dir <= L, bnc <= 0, busy <= 0, wrap <= 0.
REQ-027 rst mid-run takes effect at that edge; the run does not resume after rst is released.

Structure
REQ-028 Shared package led_flow_pkg holds:
  - state encodings IDLE/RUN/HOLD;
  - mode encodings MODE_NONE/LEFT/RIGHT/BOUNCE;
  - pattern constants PAT_LSB=0000_0001 and PAT_MSB=1000_0000.
REQ-029 One sub-module, led_tick_gen, holds the prescaler counter. Its inputs are clk, rst, en and clr; its output is tick.

Verification (TICK_DIV=4 unless stated)
REQ-030 Reset: assert rst 2 cycles -> led=0000_0001, busy=0, wrap=0.
REQ-031 Left run: start with mode=01 at edge N -> led=0000_0010 at N+4. After 32 cycles led=0000_0001 again, with wrap pulsing one cycle at that step.
REQ-032 Right run: start with mode=10 -> led=1000_0000 immediately, then 0100_0000 four cycles later.
REQ-033 Bounce run: mode=11 -> sequence 01,02,..,80,40,..,01,02, with wrap pulses at 80->40 and 01->02 only.
REQ-034 Pause: pause high for 10 cycles mid-count in a left run -> next step delayed by exactly 11 cycles and cnt phase preserved.
REQ-035 Same-cycle start+stop while running with led=0001_0000 -> IDLE, busy=0, led stays 0001_0000. A mid-run rst then gives the reset values of REQ-026.

Source files
------------

// File: rtl/led_flow_pkg.sv
// Shared encodings and pattern constants for the LED flow controller.
// The LED vector is 8 bits wide in this release.
package led_flow_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    localparam logic [LED_W-1:0] PAT_LSB = 8'b0000_0001;
    localparam logic [LED_W-1:0] PAT_MSB = 8'b1000_0000;

    // Right rotation starts from the top end; left and bounce start at the bottom.
    function automatic logic [LED_W-1:0] start_pat(input mode_t m);
        return (m == MODE_RIGHT) ? PAT_MSB : PAT_LSB;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler for LED stepping: tick fires on the enabled cycle that closes
// each group of TICK_DIV enabled cycles; clr restarts the phase.
module led_tick_gen
    import led_flow_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // The counter only ever moves when enabled, so a pause keeps its phase.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// LED chaser: rotate-left, rotate-right or bounce a single lit LED, one
// position per TICK_DIV run cycles, with start/stop/pause control.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             wrap
);

    state_t state;
    logic   dir;   // 0 = left (towards MSB), 1 = right
    logic   bnc;
    logic   tick;

    logic active, do_stop, do_start, cnt_en;

    assign active   = (state != IDLE);
    assign do_stop  = stop && active;
    assign do_start = start && !stop && (mode != MODE_NONE);
    assign cnt_en   = (state == RUN) && !pause && !do_stop && !do_start;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (do_stop || do_start),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            led   <= PAT_LSB;
            state <= IDLE;
            dir   <= 1'b0;
            bnc   <= 1'b0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (do_stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (do_start) begin
                led   <= start_pat(mode_t'(mode));
                state <= RUN;
                busy  <= 1'b1;
                dir   <= (mode == MODE_RIGHT);
                bnc   <= (mode == MODE_BOUNCE);
            end else begin
                case (state)
                    RUN: begin
                        if (pause) begin
                            state <= HOLD;
                        end else if (tick) begin
                            // Bounce reverses at the ends instead of wrapping around.
                            if (bnc && !dir && led == PAT_MSB) begin
                                led  <= PAT_MSB >> 1;
                                dir  <= 1'b1;
                                wrap <= 1'b1;
                            end else if (bnc && dir && led == PAT_LSB) begin
                                led  <= PAT_LSB << 1;
                                dir  <= 1'b0;
                                wrap <= 1'b1;
                            end else if (!dir) begin
                                led  <= {led[WIDTH-2:0], led[WIDTH-1]};
                                wrap <= (led == PAT_MSB);
                            end else begin
                                led  <= {led[0], led[WIDTH-1:1]};
                                wrap <= (led == PAT_LSB);
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause)
                            state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed and random checks of led_flow_ctrl against a position-based model.
module tb_led_flow_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [1:0] mode;
    logic [7:0] led;
    logic       busy, wrap;

    int tests = 0;
    int fails = 0;

    // Model: lit position 0..7, direction +1/-1, cycles counted toward the next step.
    bit m_act, m_hold, m_bnc, m_wrap;
    int m_pos, m_dir, m_phase;

    always #5 clk = ~clk;

    led_flow_ctrl #(.TICK_DIV(TD), .WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .mode  (mode),
        .led   (led),
        .busy  (busy),
        .wrap  (wrap)
    );

    function automatic void model_edge(bit r, bit s, bit st, bit p, logic [1:0] md);
        int np;
        m_wrap = 1'b0;
        if (r) begin
            m_pos = 0; m_dir = 1; m_bnc = 0;
            m_act = 0; m_hold = 0; m_phase = 0;
        end else if (st && m_act) begin
            m_act = 0; m_hold = 0; m_phase = 0;
        end else if (s && !st && md != 2'b00) begin
            m_act = 1; m_hold = 0; m_phase = 0;
            m_pos = (md == 2'b10) ? 7 : 0;
            m_dir = (md == 2'b10) ? -1 : 1;
            m_bnc = (md == 2'b11);
        end else if (m_act) begin
            if (m_hold) begin
                if (!p) m_hold = 0;
            end else if (p) begin
                m_hold = 1;
            end else begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    np = m_pos + m_dir;
                    if (np > 7 || np < 0) begin
                        m_wrap = 1;
                        if (m_bnc) begin
                            m_dir = -m_dir;
                            m_pos = m_pos + m_dir;
                        end else begin
                            m_pos = (np + 8) % 8;
                        end
                    end else begin
                        m_pos = np;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit st, input bit p, input logic [1:0] md);
        logic [7:0] e;
        rst = r; start = s; stop = st; pause = p; mode = md;
        @(posedge clk);
        model_edge(r, s, st, p, md);
        #1;
        e = 8'b1 << m_pos;
        chk("led", led, e);
        chk("busy", {7'b0, busy}, {7'b0, m_act});
        chk("wrap", {7'b0, wrap}, {7'b0, m_wrap});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00);
    endtask

    initial begin
        int wc;
        bit pz;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00;

        // Reset held for two cycles.
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        chk("reset_led", led, 8'h01);
        chk("reset_busy", {7'b0, busy}, 8'h00);
        chk("reset_wrap", {7'b0, wrap}, 8'h00);

        // Left run: first step 4 edges after start, full circle after 32.
        step(0, 1, 0, 0, 2'b01);
        idle(3);
        chk("left_n3", led, 8'h01);
        idle(1);
        chk("left_n4", led, 8'h02);
        idle(27);
        chk("left_n31", led, 8'h80);
        idle(1);
        chk("left_n32_led", led, 8'h01);
        chk("left_n32_wrap", {7'b0, wrap}, 8'h01);
        idle(1);
        chk("left_wrap_1cyc", {7'b0, wrap}, 8'h00);

        // Right run restarts from MSB.
        step(0, 1, 0, 0, 2'b10);
        chk("right_n0", led, 8'h80);
        idle(4);
        chk("right_n4", led, 8'h40);

        // Bounce: 15 steps reach 02 with exactly two reversals.
        step(0, 1, 0, 0, 2'b11);
        wc = 0;
        for (int i = 0; i < 15 * TD; i++) begin
            step(0, 0, 0, 0, 2'b00);
            if (wrap) wc++;
        end
        chk("bounce_wraps", 8'(wc), 8'd2);
        chk("bounce_led", led, 8'h02);

        // Pause for 10 cycles after two counted cycles: step lands at N+15.
        step(0, 1, 0, 0, 2'b01);
        idle(2);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 2'b00);
        chk("pause_busy", {7'b0, busy}, 8'h01);
        idle(2);
        chk("pause_n14", led, 8'h01);
        idle(1);
        chk("pause_n15", led, 8'h02);

        // Start+stop together while running: stop wins, pattern held.
        step(0, 1, 0, 0, 2'b01);
        idle(4 * TD);
        chk("pre_stop", led, 8'h10);
        step(0, 1, 1, 0, 2'b01);
        chk("stop_led", led, 8'h10);
        chk("stop_busy", {7'b0, busy}, 8'h00);
        idle(6);
        chk("idle_hold", led, 8'h10);
        step(0, 1, 0, 0, 2'b00);
        chk("mode0_ignored", {7'b0, busy}, 8'h00);

        // Mid-run reset; run must not resume.
        step(0, 1, 0, 0, 2'b10);
        idle(5);
        step(1, 0, 0, 0, 2'b00);
        chk("midrst_led", led, 8'h01);
        chk("midrst_busy", {7'b0, busy}, 8'h00);
        idle(8);
        chk("midrst_stays", led, 8'h01);

        // Random traffic against the model.
        pz = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, s, st;
            logic [1:0] md;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 99) < 6);
            st = ($urandom_range(0, 99) < 3);
            md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pz = ~pz;
            step(r, s, st, pz, md);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
